// File: rtl/y_demux_collect_pkg.sv
// Shared types and defaults for the word demux/collector.
// State encoding and default word width.
package y_demux_collect_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam int WORD_W = 32;

endpackage

// File: rtl/y_lane_reg.sv
// One lane register of the collector.
// Loads d when we is high; cleared asynchronously.
module y_lane_reg
  import y_demux_collect_pkg::*;
#(
  parameter int SIZE = WORD_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [SIZE-1:0] q_d;
  logic [SIZE-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (we) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/y_demux_collect.sv
// Steers 32-bit words into LANES lane registers and hands the
// assembled wide word downstream once every lane is fresh.
module y_demux_collect
  import y_demux_collect_pkg::*;
#(
  parameter int SIZE  = WORD_W,
  parameter int LANES = 4,
  localparam int SELW = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SIZE-1:0]       in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [SIZE*LANES-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      fill_mask,
  output logic                  sel_err
);

  localparam logic [SELW:0] LANES_W = (SELW + 1)'(LANES);

  state_e           state_d;
  state_e           state_q;
  logic [LANES-1:0] mask_d;
  logic [LANES-1:0] mask_q;
  logic             in_ready_d;
  logic             in_ready_q;
  logic             sel_err_d;
  logic             sel_err_q;

  logic             accept;
  logic             sel_ok;
  logic [LANES-1:0] we;

  assign accept = in_valid && in_ready_q;
  assign sel_ok = {1'b0, in_sel} < LANES_W;

  // Out-of-range selects match no lane, so they never write.
  always_comb begin
    we = '0;
    for (int k = 0; k < LANES; k++) begin
      if (accept && (in_sel == SELW'(k))) begin
        we[k] = 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    y_lane_reg #(
      .SIZE(SIZE)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .we   (we[k]),
      .d    (in_data),
      .q    (out_data[k*SIZE +: SIZE])
    );
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    sel_err_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          sel_err_d = !sel_ok;
          mask_d    = mask_q | we;
          if (&mask_d) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
          mask_d  = '0;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
    in_ready_d = (state_d == FILL);
  end

  // in_ready stays low through reset and rises one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      mask_q     <= '0;
      in_ready_q <= 1'b0;
      sel_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      in_ready_q <= in_ready_d;
      sel_err_q  <= sel_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == FULL);
  assign fill_mask = mask_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_y_demux_collect.sv
// Scoreboard bench for y_demux_collect.
// Drives a LANES=4 and a LANES=3 instance.
module tb_y_demux_collect;

  logic clk;
  logic rst_n;

  logic [31:0]  d4;
  logic [1:0]   s4;
  logic         v4;
  logic         rdy4;
  logic [127:0] od4;
  logic         ov4;
  logic         r4;
  logic [3:0]   fm4;
  logic         se4;

  logic [31:0]  d3;
  logic [1:0]   s3;
  logic         v3;
  logic         rdy3;
  logic [95:0]  od3;
  logic         ov3;
  logic         r3;
  logic [2:0]   fm3;
  logic         se3;

  int checks;
  int errors;

  logic [31:0]  m4 [4];
  logic [3:0]   mm4;
  logic         ms4;
  logic [127:0] sb4 [$];
  logic [95:0]  sb3 [$];

  y_demux_collect #(.SIZE(32), .LANES(4)) u4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (d4),
    .in_sel   (s4),
    .in_valid (v4),
    .in_ready (rdy4),
    .out_data (od4),
    .out_valid(ov4),
    .out_ready(r4),
    .fill_mask(fm4),
    .sel_err  (se4)
  );

  y_demux_collect #(.SIZE(32), .LANES(3)) u3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (d3),
    .in_sel   (s3),
    .in_valid (v3),
    .in_ready (rdy3),
    .out_data (od3),
    .out_valid(ov3),
    .out_ready(r3),
    .fill_mask(fm3),
    .sel_err  (se3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic mdl_clear4();
    for (int i = 0; i < 4; i++) m4[i] = '0;
    mm4 = '0;
    ms4 = 1'b0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic put4(input logic [1:0] s, input logic [31:0] d);
    chk("rdy4", 128'(rdy4), 128'(!ms4));
    v4 = 1'b1;
    s4 = s;
    d4 = d;
    @(posedge clk);
    if (!ms4) begin
      m4[s]  = d;
      mm4[s] = 1'b1;
      if (&mm4) begin
        ms4 = 1'b1;
        sb4.push_back({m4[3], m4[2], m4[1], m4[0]});
      end
    end
    @(negedge clk);
    v4 = 1'b0;
  endtask

  task automatic drain4();
    int n;
    n = 0;
    while (!ov4 && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!ov4) begin
      chk("drain4_timeout", 128'(ov4), 128'(1));
      return;
    end
    if (sb4.size() == 0) begin
      chk("sb4_empty", 128'(ov4), 128'(0));
      return;
    end
    chk("od4", od4, sb4.pop_front());
    r4 = 1'b1;
    @(posedge clk);
    ms4 = 1'b0;
    mm4 = '0;
    @(negedge clk);
    r4 = 1'b0;
    chk("drain4_mask", 128'(fm4), 128'(mm4));
    chk("drain4_rdy", 128'(rdy4), 128'(1));
    chk("drain4_ov", 128'(ov4), 128'(0));
  endtask

  task automatic put3(input logic [1:0] s, input logic [31:0] d);
    v3 = 1'b1;
    s3 = s;
    d3 = d;
    @(posedge clk);
    @(negedge clk);
    v3 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    v4 = 1'b0; s4 = '0; d4 = '0; r4 = 1'b0;
    v3 = 1'b0; s3 = '0; d3 = '0; r3 = 1'b0;
    mdl_clear4();

    // Reset and release
    repeat (2) @(negedge clk);
    chk("rst_rdy", 128'(rdy4), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", 128'(rdy4), 128'(1));
    chk("rel_ov", 128'(ov4), 128'(0));
    chk("rel_mask", 128'(fm4), 128'(0));
    chk("rel_data", od4, 128'(0));

    // In-order fill
    put4(2'd0, 32'h11111111);
    put4(2'd1, 32'h22222222);
    put4(2'd2, 32'h33333333);
    put4(2'd3, 32'h44444444);
    chk("ord_ov", 128'(ov4), 128'(1));
    chk("ord_rdy", 128'(rdy4), 128'(0));
    chk("ord_data", od4,
        128'h44444444_33333333_22222222_11111111);
    drain4();

    // Overwrite and out-of-order fill
    put4(2'd2, 32'hAAAAAAAA);
    put4(2'd2, 32'hBBBBBBBB);
    chk("ovw_mask", 128'(fm4), 128'(4'b0100));
    put4(2'd0, 32'hCCCCCCCC);
    put4(2'd3, 32'hDDDDDDDD);
    chk("ovw_notfull", 128'(ov4), 128'(0));
    put4(2'd1, 32'hEEEEEEEE);
    chk("ovw_ov", 128'(ov4), 128'(1));
    chk("ovw_lane2", 128'(od4[95:64]), 128'(32'hBBBBBBBB));
    drain4();

    // out_ready while filling is ignored
    put4(2'd0, 32'h01010101);
    r4 = 1'b1;
    @(negedge clk);
    r4 = 1'b0;
    chk("fill_ordy_mask", 128'(fm4), 128'(mm4));
    chk("fill_ordy_rdy", 128'(rdy4), 128'(1));

    // Backpressure in FULL
    put4(2'd1, 32'h02020202);
    put4(2'd2, 32'h03030303);
    put4(2'd3, 32'h04040404);
    for (int i = 0; i < 5; i++) begin
      v4 = 1'b1;
      s4 = 2'(i);
      d4 = 32'hF000_0000 | 32'(i);
      @(negedge clk);
      chk("bp_data", od4, sb4[0]);
      chk("bp_mask", 128'(fm4), 128'(4'b1111));
      chk("bp_rdy", 128'(rdy4), 128'(0));
    end
    v4 = 1'b0;
    drain4();

    // Bad select on three-lane instance
    put3(2'd0, 32'hAAAA0000);
    put3(2'd3, 32'hDEADBEEF);
    chk("bad_err", 128'(se3), 128'(1));
    chk("bad_mask", 128'(fm3), 128'(3'b001));
    chk("bad_data", 128'(od3), 128'({64'd0, 32'hAAAA0000}));
    @(negedge clk);
    chk("bad_err_pulse", 128'(se3), 128'(0));
    put3(2'd1, 32'hBBBB1111);
    sb3.push_back({32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000});
    put3(2'd2, 32'hCCCC2222);
    chk("l3_ov", 128'(ov3), 128'(1));
    chk("l3_err", 128'(se3), 128'(0));
    chk("l3_data", 128'(od3), 128'(sb3.pop_front()));
    r3 = 1'b1;
    @(negedge clk);
    r3 = 1'b0;
    chk("l3_drain_mask", 128'(fm3), 128'(0));
    chk("l3_drain_rdy", 128'(rdy3), 128'(1));

    // Asynchronous reset mid-fill
    put4(2'd0, 32'h55555555);
    put4(2'd1, 32'h66666666);
    chk("mid_mask", 128'(fm4), 128'(4'b0011));
    #2;
    rst_n = 1'b0;
    mdl_clear4();
    #1;
    chk("ar_mask", 128'(fm4), 128'(0));
    chk("ar_data", od4, 128'(0));
    chk("ar_rdy", 128'(rdy4), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_rel_rdy", 128'(rdy4), 128'(1));
    put4(2'd0, 32'h11111111);
    put4(2'd1, 32'h22222222);
    put4(2'd2, 32'h33333333);
    put4(2'd3, 32'h44444444);
    chk("ar_ord_ov", 128'(ov4), 128'(1));
    chk("ar_ord_data", od4,
        128'h44444444_33333333_22222222_11111111);
    drain4();

    chk("sb4_left", 128'(sb4.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
